// File: rtl/move_list_reader_pkg.sv
// Shared types and constants for move_list_reader: reader FSM states, default
// sizing and the "no en-passant column" value also used by all_moves.
package move_list_reader_pkg;

  localparam int         PIECE_BITS        = 4;
  localparam int         MAX_POSITIONS_DEF = 64;
  localparam logic [3:0] EP_NONE           = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LIST = 3'd1,
    ST_FETCH     = 3'd2,
    ST_WAIT_DATA = 3'd3,
    ST_PRESENT   = 3'd4,
    ST_CLEAR     = 3'd5
  } rd_state_e;

endpackage

// File: rtl/move_list_reader.sv
// Drains the child-position list of all_moves onto a valid/ready stream, then
// pulses am_clear_moves so all_moves can accept the next board.
module move_list_reader
  import move_list_reader_pkg::*;
#(
  parameter int PIECE_WIDTH        = PIECE_BITS,
  parameter int SIDE_WIDTH         = PIECE_WIDTH * 8,
  parameter int BOARD_WIDTH        = SIDE_WIDTH * 8,
  parameter int MAX_POSITIONS      = MAX_POSITIONS_DEF,
  parameter int MAX_POSITIONS_LOG2 = $clog2(MAX_POSITIONS),
  parameter int READ_LATENCY       = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          am_moves_ready,
  input  logic [MAX_POSITIONS_LOG2-1:0] am_move_count,
  output logic [MAX_POSITIONS_LOG2-1:0] am_move_index,
  input  logic [BOARD_WIDTH-1:0]        am_board,
  input  logic                          am_white_to_move,
  input  logic [3:0]                    am_castle_mask,
  input  logic [3:0]                    am_en_passant_col,
  output logic                          am_clear_moves,
  output logic                          pos_valid,
  input  logic                          pos_ready,
  output logic [BOARD_WIDTH-1:0]        pos_board,
  output logic                          pos_white_to_move,
  output logic [3:0]                    pos_castle_mask,
  output logic [3:0]                    pos_en_passant_col,
  output logic [MAX_POSITIONS_LOG2-1:0] pos_index,
  output logic                          pos_last,
  output logic                          done,
  output logic                          no_moves
);

  localparam int               LW       = MAX_POSITIONS_LOG2;
  localparam int               LAT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY - 1);

  rd_state_e        state_r, state_s;
  logic [LW-1:0]    index_r, index_s;
  logic [LW-1:0]    count_r, count_s;
  logic [LAT_W-1:0] lat_r, lat_s;
  logic             valid_r, valid_s;
  logic             clear_r, clear_s;
  logic             done_r, done_s;
  logic             no_moves_r, no_moves_s;
  logic             capture_s;
  logic             last_s;

  logic [BOARD_WIDTH-1:0] board_r;
  logic                   wtm_r;
  logic [3:0]             castle_r;
  logic [3:0]             ep_r;
  logic [LW-1:0]          pidx_r;
  logic                   last_r;

  // Next-state and next-output logic for the drain sequencer.
  always_comb begin
    state_s    = state_r;
    index_s    = index_r;
    count_s    = count_r;
    lat_s      = lat_r;
    valid_s    = valid_r;
    clear_s    = 1'b0;
    done_s     = 1'b0;
    no_moves_s = no_moves_r;
    capture_s  = 1'b0;
    last_s     = (index_r == (count_r - LW'(1'b1)));

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s    = ST_WAIT_LIST;
          no_moves_s = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_LIST: begin
        if (am_moves_ready) begin
          count_s = am_move_count;
          index_s = {LW{1'b0}};
          if (am_move_count == {LW{1'b0}}) begin
            state_s    = ST_CLEAR;
            clear_s    = 1'b1;
            done_s     = 1'b1;
            no_moves_s = 1'b1;
          end else begin
            state_s = ST_FETCH;
          end
        end else begin
          state_s = ST_WAIT_LIST;
        end
      end
      ST_FETCH: begin
        if (!am_moves_ready) begin
          state_s = ST_IDLE;
        end else begin
          lat_s   = LAT_LOAD;
          state_s = ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        if (!am_moves_ready) begin
          state_s = ST_IDLE;
        end else if (lat_r == {LAT_W{1'b0}}) begin
          capture_s = 1'b1;
          valid_s   = 1'b1;
          state_s   = ST_PRESENT;
        end else begin
          lat_s = lat_r - LAT_W'(1'b1);
        end
      end
      ST_PRESENT: begin
        // A vanished list aborts quietly: no clear pulse, no done.
        if (!am_moves_ready) begin
          valid_s = 1'b0;
          state_s = ST_IDLE;
        end else if (pos_ready) begin
          valid_s = 1'b0;
          if (last_r) begin
            state_s = ST_CLEAR;
            clear_s = 1'b1;
            done_s  = 1'b1;
          end else begin
            index_s = index_r + LW'(1'b1);
            state_s = ST_FETCH;
          end
        end else begin
          state_s = ST_PRESENT;
        end
      end
      ST_CLEAR: begin
        state_s = ST_IDLE;
      end
      default: begin
        valid_s = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and registered control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      index_r    <= {LW{1'b0}};
      count_r    <= {LW{1'b0}};
      lat_r      <= {LAT_W{1'b0}};
      valid_r    <= 1'b0;
      clear_r    <= 1'b0;
      done_r     <= 1'b0;
      no_moves_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      index_r    <= index_s;
      count_r    <= count_s;
      lat_r      <= lat_s;
      valid_r    <= valid_s;
      clear_r    <= clear_s;
      done_r     <= done_s;
      no_moves_r <= no_moves_s;
    end
  end

  // Output holding register: loads once per entry and holds through stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      board_r  <= {BOARD_WIDTH{1'b0}};
      wtm_r    <= 1'b0;
      castle_r <= 4'b0000;
      ep_r     <= EP_NONE;
      pidx_r   <= {LW{1'b0}};
      last_r   <= 1'b0;
    end else if (capture_s) begin
      board_r  <= am_board;
      wtm_r    <= am_white_to_move;
      castle_r <= am_castle_mask;
      ep_r     <= am_en_passant_col;
      pidx_r   <= index_r;
      last_r   <= last_s;
    end
  end

  assign am_move_index      = index_r;
  assign am_clear_moves     = clear_r;
  assign done               = done_r;
  assign no_moves           = no_moves_r;
  assign pos_valid          = valid_r;
  assign pos_board          = board_r;
  assign pos_white_to_move  = wtm_r;
  assign pos_castle_mask    = castle_r;
  assign pos_en_passant_col = ep_r;
  assign pos_index          = pidx_r;
  assign pos_last           = last_r;

endmodule
